// File: rtl/dual_port_mem_responder.sv
// rtl/dual_port_mem_responder.sv - two-initiator req/gnt/rvalid responder over one single-ported word array
// Optional feature: MEM_RESP_ERR_EN flags out-of-range and misaligned accesses with err=1.
module dual_port_mem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] FLAG_ADDR   = 32'h0000_1000,
    parameter logic [31:0] RESULT_ADDR = 32'h0000_1004
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p1_req_i,
    output logic        p1_gnt_o,
    output logic        p1_rvalid_o,
    input  logic [31:0] p1_addr_i,
    input  logic        p1_we_i,
    input  logic [3:0]  p1_be_i,
    input  logic [31:0] p1_wdata_i,
    output logic [31:0] p1_rdata_o,
    output logic        p1_err_o,
    input  logic        p2_req_i,
    output logic        p2_gnt_o,
    output logic        p2_rvalid_o,
    input  logic [31:0] p2_addr_i,
    input  logic        p2_we_i,
    input  logic [3:0]  p2_be_i,
    input  logic [31:0] p2_wdata_i,
    output logic [31:0] p2_rdata_o,
    output logic        p2_err_o,
    output logic [31:0] mem_flag_o,
    output logic [31:0] mem_result_o
);
    localparam int IW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic          ptr;          // 0: port 1 wins a conflict, 1: port 2 wins
    logic          rvalid1_q;
    logic          rvalid2_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   flag_q;
    logic [31:0]   result_q;

    logic          gnt1;
    logic          gnt2;
    logic          acc;
    logic [31:0]   a_addr;
    logic [31:0]   a_wdata;
    logic [3:0]    a_be;
    logic          a_we;
    logic [IW-1:0] idx;
    logic          is_flag;
    logic          is_result;
    logic          a_err;
    logic          wr_en;
    logic [31:0]   rd_val;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    always_comb begin
        gnt1 = !rst_i && p1_req_i && (!p2_req_i || !ptr);
        gnt2 = !rst_i && p2_req_i && (!p1_req_i || ptr);
    end

    // At most one grant per cycle, so the array sees a single muxed access.
    always_comb begin
        acc     = gnt1 || gnt2;
        a_addr  = gnt2 ? p2_addr_i  : p1_addr_i;
        a_wdata = gnt2 ? p2_wdata_i : p1_wdata_i;
        a_be    = gnt2 ? p2_be_i    : p1_be_i;
        a_we    = gnt2 ? p2_we_i    : p1_we_i;
    end

    assign idx       = a_addr[IW+1:2];
    assign is_flag   = (a_addr[31:2] == FLAG_ADDR[31:2]);
    assign is_result = (a_addr[31:2] == RESULT_ADDR[31:2]);

`ifdef MEM_RESP_ERR_EN
    assign a_err = (!(is_flag || is_result) && (|a_addr[31:IW+2])) || (|a_addr[1:0]);
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^a_addr[1:0];
    assign a_err = 1'b0;
`endif

    assign wr_en = acc && a_we && !a_err;

    always_comb begin
        rd_val = 32'h0;
        if (a_err)          rd_val = 32'hDEAD_BEEF;
        else if (a_we)      rd_val = 32'h0;
        else if (is_flag)   rd_val = flag_q;
        else if (is_result) rd_val = result_q;
        else                rd_val = mem[idx];
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !is_flag && !is_result) begin
            for (int k = 0; k < 4; k++) begin
                if (a_be[k]) mem[idx][8*k +: 8] <= a_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr       <= 1'b0;
            rvalid1_q <= 1'b0;
            rvalid2_q <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            flag_q    <= 32'h0;
            result_q  <= 32'h0;
        end else begin
            rvalid1_q <= gnt1;
            rvalid2_q <= gnt2;
            if (acc) begin
                rdata_q <= rd_val;
                err_q   <= a_err;
            end
            if (gnt1)      ptr <= 1'b1;
            else if (gnt2) ptr <= 1'b0;
            if (wr_en && is_flag)   flag_q   <= merge(flag_q, a_wdata, a_be);
            if (wr_en && is_result) result_q <= merge(result_q, a_wdata, a_be);
        end
    end

    // Responses are masked while reset is asserted so a pending one never escapes.
    assign p1_gnt_o     = gnt1;
    assign p2_gnt_o     = gnt2;
    assign p1_rvalid_o  = rvalid1_q && !rst_i;
    assign p2_rvalid_o  = rvalid2_q && !rst_i;
    assign p1_rdata_o   = p1_rvalid_o ? rdata_q : 32'h0;
    assign p2_rdata_o   = p2_rvalid_o ? rdata_q : 32'h0;
    assign p1_err_o     = p1_rvalid_o && err_q;
    assign p2_err_o     = p2_rvalid_o && err_q;
    assign mem_flag_o   = flag_q;
    assign mem_result_o = result_q;
endmodule
